// File: rtl/multiword_sbc_if.sv
// Valid/ready operand and result bundle for the multi-cycle subtract-with-borrow unit.
// Adds the OV signal when SBC_OVERFLOW_EN is defined.
interface multiword_sbc_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] I0;
  logic [WIDTH-1:0] I1;
  logic             BIN;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] O;
  logic             BOUT;
  logic             busy;
`ifdef SBC_OVERFLOW_EN
  logic             OV;
`endif

  // The producer/consumer side drives operands and out_ready.
  modport master (
    output in_valid, I0, I1, BIN, out_ready,
`ifdef SBC_OVERFLOW_EN
    input  OV,
`endif
    input  in_ready, out_valid, O, BOUT, busy
  );

  modport slave (
    input  in_valid, I0, I1, BIN, out_ready,
`ifdef SBC_OVERFLOW_EN
    output OV,
`endif
    output in_ready, out_valid, O, BOUT, busy
  );
endinterface

// File: rtl/multiword_sbc.sv
// Multi-cycle unsigned subtract-with-borrow, SLICE bits per clock, LSB slice first.
// Optional signed-overflow output enabled by defining SBC_OVERFLOW_EN.
module multiword_sbc #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic          CLK,
  input  logic          ASYNCRESETN,
  multiword_sbc_if.slave sbc
);

  localparam int SAFE_SLICE = (SLICE < 1) ? 1 : SLICE;
  localparam int NSLICE     = WIDTH / SAFE_SLICE;
  localparam int CW         = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NSLICE - 1);

  if (SLICE < 1 || (WIDTH % SAFE_SLICE) != 0) begin : g_badParam
    $fatal(1, "multiword_sbc: WIDTH must be a positive multiple of SLICE");
  end
  if ($bits(sbc.I0) != WIDTH) begin : g_badIfWidth
    $fatal(1, "multiword_sbc: interface WIDTH differs from module WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] opA_q;
  logic [WIDTH-1:0] opB_q;
  logic [WIDTH-1:0] result_q;
  logic             borrow_q;
  logic [CW-1:0]    sliceIdx_q;
  logic             bout_q;
  logic             inReady_q;
  logic             outValid_q;
  logic             busy_q;
`ifdef SBC_OVERFLOW_EN
  logic             ov_q;
`endif

  // Operands shift right each RUN cycle, so the active slice is always the low SLICE bits.
  logic [SLICE:0]         diff_d;
  logic [WIDTH+SLICE-1:0] resultCat_d;

  always_comb begin
    diff_d      = {1'b0, opA_q[SLICE-1:0]} - {1'b0, opB_q[SLICE-1:0]}
                  - {{SLICE{1'b0}}, borrow_q};
    resultCat_d = {diff_d[SLICE-1:0], result_q};
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q    <= IDLE;
      opA_q      <= '0;
      opB_q      <= '0;
      result_q   <= '0;
      borrow_q   <= 1'b0;
      sliceIdx_q <= '0;
      bout_q     <= 1'b0;
      inReady_q  <= 1'b1;
      outValid_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef SBC_OVERFLOW_EN
      ov_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (sbc.in_valid && inReady_q) begin
            opA_q      <= sbc.I0;
            opB_q      <= sbc.I1;
            borrow_q   <= sbc.BIN;
            sliceIdx_q <= '0;
            inReady_q  <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          // Result slices enter from the top, so after NSLICE shifts slice 0 sits at the LSB.
          result_q   <= resultCat_d[WIDTH+SLICE-1:SLICE];
          opA_q      <= opA_q >> SLICE;
          opB_q      <= opB_q >> SLICE;
          borrow_q   <= diff_d[SLICE];
          sliceIdx_q <= sliceIdx_q + 1'b1;
          if (sliceIdx_q == LAST_IDX) begin
            bout_q     <= diff_d[SLICE];
`ifdef SBC_OVERFLOW_EN
            ov_q       <= (opA_q[SLICE-1] != opB_q[SLICE-1]) &&
                          (diff_d[SLICE-1] != opA_q[SLICE-1]);
`endif
            outValid_q <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          if (outValid_q && sbc.out_ready) begin
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          inReady_q  <= 1'b1;
          outValid_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign sbc.in_ready  = inReady_q;
  assign sbc.out_valid = outValid_q;
  assign sbc.O         = result_q;
  assign sbc.BOUT      = bout_q;
  assign sbc.busy      = busy_q;
`ifdef SBC_OVERFLOW_EN
  assign sbc.OV        = ov_q;
`endif

endmodule
